// File: rtl/wddl_pkg.sv
// Shared types and constants for the WDDL register stage: sequencer state and
// the precharge (spacer) rail pair.
package wddl_pkg;

    typedef enum logic {
        PRE  = 1'b0,
        EVAL = 1'b1
    } state_t;

    typedef struct packed {
        logic p;
        logic n;
    } rail_pair_t;

    // Spacer value driven on both rails between tokens.
    localparam rail_pair_t PRECHARGE = '{p: 1'b0, n: 1'b0};

endpackage

// File: rtl/wddl_cw_check.sv
// Combinational dual-rail codeword checker: flags any bit whose rails are
// 00 or 11 (both are illegal at capture time).
module wddl_cw_check #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] d_p,
    input  logic [WIDTH-1:0] d_n,
    output logic             bad_cw
);

    logic [WIDTH-1:0] bad_bit;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign bad_bit[gi] = ~(d_p[gi] ^ d_n[gi]);
        end
    endgenerate

    assign bad_cw = |bad_bit;

endmodule

// File: rtl/wddl_reg_stage.sv
// Dual-rail WDDL pipeline register with a PRE/EVAL sequencer that forces an
// all-zero precharge cycle between tokens. Optional checker: WDDL_REG_CHECK_EN.
module wddl_reg_stage
    import wddl_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic [WIDTH-1:0]     d_p_in,
    input  logic [WIDTH-1:0]     d_n_in,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [WIDTH-1:0]     d_p_out,
    output logic [WIDTH-1:0]     d_n_out,
    output logic                 phase_out,
    output logic                 err_out,
    output logic [ERR_CNT_W-1:0] err_cnt_out
);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] d_p_reg;
    logic [WIDTH-1:0] d_n_reg;
    logic             capture;

    assign capture = (state_reg == PRE) && valid_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= PRE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            PRE:     if (valid_in) state_next = EVAL;
            EVAL:    if (ready_in) state_next = PRE;
            default: state_next = PRE;
        endcase
    end

    // Outputs depend on state only, so no combinational handshake paths exist.
    always_comb begin
        valid_out = (state_reg == EVAL);
        phase_out = (state_reg == EVAL);
        ready_out = (state_reg == PRE);
    end

    // Data registers are zero whenever the stage is in PRE; illegal words are
    // captured verbatim.
    always_ff @(posedge clk_in) begin
        if (rst_in || ((state_reg == EVAL) && ready_in)) begin
            d_p_reg <= {WIDTH{PRECHARGE.p}};
            d_n_reg <= {WIDTH{PRECHARGE.n}};
        end else if (capture) begin
            d_p_reg <= d_p_in;
            d_n_reg <= d_n_in;
        end
    end

    assign d_p_out = d_p_reg;
    assign d_n_out = d_n_reg;

`ifdef WDDL_REG_CHECK_EN
    logic                 bad_cw;
    logic                 err_reg;
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    wddl_cw_check #(
        .WIDTH (WIDTH)
    ) u_cw_check (
        .d_p    (d_p_in),
        .d_n    (d_n_in),
        .bad_cw (bad_cw)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else if (capture && bad_cw) begin
            err_reg <= 1'b1;
            if (err_cnt_reg != {ERR_CNT_W{1'b1}}) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end
    end

    assign err_out     = err_reg;
    assign err_cnt_out = err_cnt_reg;
`else
    assign err_out     = 1'b0;
    assign err_cnt_out = '0;
`endif

endmodule

// File: tb/tb_wddl_reg_stage.sv
// Self-checking bench for wddl_reg_stage: directed scenarios with literal
// expectations plus randomized traffic checked against a token-level model.
module tb_wddl_reg_stage;

    localparam int W   = 8;
    localparam int CW  = 8;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid_in = 1'b0;
    logic          ready_in = 1'b0;
    logic [W-1:0]  d_p_in = '0;
    logic [W-1:0]  d_n_in = '0;
    logic          ready_out, valid_out, phase_out, err_out;
    logic [W-1:0]  d_p_out, d_n_out;
    logic [CW-1:0] err_cnt_out;

    int checks = 0;
    int errors = 0;

    wddl_reg_stage #(.WIDTH(W), .ERR_CNT_W(CW)) dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .d_p_in      (d_p_in),
        .d_n_in      (d_n_in),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .d_p_out     (d_p_out),
        .d_n_out     (d_n_out),
        .phase_out   (phase_out),
        .err_out     (err_out),
        .err_cnt_out (err_cnt_out)
    );

    always #5 clk = ~clk;

`ifdef WDDL_REG_CHECK_EN
    localparam bit CHECKER = 1'b1;
`else
    localparam bit CHECKER = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Token-level model: a stage either holds one token or is empty.
    bit         started = 1'b0;
    bit         m_full = 1'b0;
    logic [W-1:0] m_p = '0, m_n = '0;
    bit         m_err = 1'b0;
    int         m_cnt = 0;

    function automatic bit word_is_legal(input logic [W-1:0] p, input logic [W-1:0] n);
        for (int i = 0; i < W; i++) begin
            if (p[i] == n[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            started = 1'b1;
            m_full  = 1'b0;
            m_p     = '0;
            m_n     = '0;
            m_err   = 1'b0;
            m_cnt   = 0;
        end else if (!m_full) begin
            if (valid_in) begin
                m_full = 1'b1;
                m_p    = d_p_in;
                m_n    = d_n_in;
                if (CHECKER && !word_is_legal(d_p_in, d_n_in)) begin
                    m_err = 1'b1;
                    if (m_cnt < SAT) m_cnt++;
                end
            end
        end else if (ready_in) begin
            m_full = 1'b0;
            m_p    = '0;
            m_n    = '0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("valid_out", valid_out, m_full);
            check("phase_out", phase_out, m_full);
            check("ready_out", ready_out, !m_full);
            check("d_p_out", d_p_out, m_p);
            check("d_n_out", d_n_out, m_n);
            check("err_out", err_out, m_err);
            check("err_cnt_out", err_cnt_out, m_cnt);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    int seen;

    initial begin
        rst = 1'b1;
        step(); step();
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_ready", ready_out, 1'b1);
            check("idle_valid", valid_out, 1'b0);
            check("idle_dp", d_p_out, 8'h00);
        end

        // Single token with ready held high.
        ready_in = 1'b1; valid_in = 1'b1; d_p_in = 8'hA5; d_n_in = 8'h5A;
        step();
        check("tok_valid", valid_out, 1'b1);
        check("tok_dp", d_p_out, 8'hA5);
        check("tok_dn", d_n_out, 8'h5A);
        check("tok_ready", ready_out, 1'b0);
        valid_in = 1'b0;
        step();
        check("pre_dp", d_p_out, 8'h00);
        check("pre_dn", d_n_out, 8'h00);
        check("pre_phase", phase_out, 1'b0);

        // Back-to-back: one token every two cycles.
        valid_in = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (valid_out) seen++;
        end
        check("b2b_tokens", seen, 4);
        valid_in = 1'b0; ready_in = 1'b1;
        step(); step();

        // Backpressure with changing inputs.
        ready_in = 1'b0; valid_in = 1'b1; d_p_in = 8'h3C; d_n_in = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_dp", d_p_out, 8'h3C);
            check("bp_ready", ready_out, 1'b0);
            d_p_in = 8'($urandom); d_n_in = ~d_p_in;
        end
        valid_in = 1'b0; ready_in = 1'b1;
        step();
        check("bp_release", valid_out, 1'b0);

        // Illegal capture and saturation.
        valid_in = 1'b1; d_p_in = 8'hFF; d_n_in = 8'h01;
        step();
        check("bad_dp", d_p_out, 8'hFF);
        check("bad_err", err_out, CHECKER);
        check("bad_cnt", err_cnt_out, CHECKER ? 1 : 0);
        for (int i = 0; i < 602; i++) step();
        valid_in = 1'b0;
        step();
        check("sat_cnt", err_cnt_out, CHECKER ? SAT : 0);
        check("sat_err", err_out, CHECKER);

        // Reset while evaluating, then reset together with valid.
        step();
        valid_in = 1'b1; d_p_in = 8'hA5; d_n_in = 8'h5A; ready_in = 1'b0;
        step();
        check("rst_pre_valid", valid_out, 1'b1);
        rst = 1'b1; valid_in = 1'b0;
        step();
        check("rst_valid", valid_out, 1'b0);
        check("rst_dp", d_p_out, 8'h00);
        check("rst_err", err_out, 1'b0);
        check("rst_cnt", err_cnt_out, 0);
        valid_in = 1'b1;
        step();
        check("rst_with_valid", valid_out, 1'b0);
        rst = 1'b0; valid_in = 1'b0;
        step();
        check("rst_no_capture", valid_out, 1'b0);

        // Randomized traffic, roughly 1 in 8 words illegal, rare resets.
        for (int i = 0; i < 3000; i++) begin
            valid_in = ($urandom_range(0, 2) != 0);
            ready_in = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 99) == 0);
            d_p_in   = 8'($urandom);
            d_n_in   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : ~d_p_in;
            step();
        end
        rst = 1'b0; valid_in = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
